if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the instruction memory and the decode stage.
- Owns the program counter and drives the fetch address to instruction memory. Memory returns the instruction combinationally from address bits [8:2].
- Registers the returned instruction and PC+4 into the IF/ID pipeline register.
- Handles hazard stalls, taken-branch redirect/squash, and out-of-range fetch faults.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/if_id_reg.sv | 49 ++++
 rtl/if_stage.sv | 124 ++++++++++++
 tb/tb_if_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline constants and types
//
// Purpose: constants and enumerations shared by the MIPS pipeline stages.
// Contents:
//   NOP           - all-zero instruction word used for squashed/faulted slots
//   PC_INC        - byte increment of the program counter per fetch
//   fetch_state_t - fetch FSM states {RUN, FAULT}
package pipeline_pkg;

  localparam logic [31:0] NOP    = 32'b0;
  localparam int          PC_INC = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold and clear
//
// Purpose: pipeline register between fetch and decode. Clear has priority
// over hold; with neither asserted the register loads its inputs.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   hold     in   keep the current contents (stall)
//   clear    in   load a bubble {pc=0, instr=NOP, valid=0}
//   pc_d     in   PC+4 of the incoming instruction
//   instr_d  in   incoming instruction
//   valid_d  in   incoming valid flag
//   pc_q     out  registered PC+4
//   instr_q  out  registered instruction
//   valid_q  out  registered valid flag
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         clear,
  input  logic [N-1:0] pc_d,
  input  logic [N-1:0] instr_d,
  input  logic         valid_d,
  output logic [N-1:0] pc_q,
  output logic [N-1:0] instr_q,
  output logic         valid_q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= N'(NOP);
      valid_q <= 1'b0;
    end else if (clear) begin
      pc_q    <= '0;
      instr_q <= N'(NOP);
      valid_q <= 1'b0;
    end else if (!hold) begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage
//
// Purpose: owns the program counter, drives the fetch address, and loads
// the IF/ID register. Handles stalls, branch redirect/squash and
// out-of-range fetch faults (RUN/FAULT FSM).
// Configuration: define IF_PERF_CNT_EN to add fetch_cnt/squash_cnt.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   freeze       in   hazard stall: hold PC, IF/ID and FSM
//   br_taken     in   taken branch: redirect PC and squash IF/ID
//   br_target    in   branch target byte address (low 2 bits ignored)
//   pc_out       out  fetch address (the PC register)
//   instr_in     in   instruction memory data for pc_out
//   if_id_pc     out  PC+4 of the registered instruction
//   if_id_instr  out  registered instruction (NOP when bubbled)
//   if_id_valid  out  IF/ID holds a real instruction
//   fetch_fault  out  FSM is in FAULT
//   fetch_cnt    out  (IF_PERF_CNT_EN) valid IF/ID loads
//   squash_cnt   out  (IF_PERF_CNT_EN) taken-branch edges
module if_stage
  import pipeline_pkg::*;
#(
  parameter int          N          = 32,
  parameter logic [N-1:0] RESET_PC  = '0,
  parameter int          IMEM_DEPTH = 91
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         br_taken,
  input  logic [N-1:0] br_target,
  output logic [N-1:0] pc_out,
  input  logic [N-1:0] instr_in,
  output logic [N-1:0] if_id_pc,
  output logic [N-1:0] if_id_instr,
  output logic         if_id_valid,
  output logic         fetch_fault
`ifdef IF_PERF_CNT_EN
  ,
  output logic [N-1:0] fetch_cnt,
  output logic [N-1:0] squash_cnt
`endif
);

  localparam logic [N-1:0] PC_LIMIT = N'(IMEM_DEPTH * 4);

  fetch_state_t state, state_n;
  logic [N-1:0] pc, pc_n, pc_plus4;
  logic         in_range;
  logic         ifid_hold, ifid_clear;

  assign pc_plus4 = pc + N'(PC_INC);
  assign in_range = (pc < PC_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ifid_hold  = 1'b0;
    ifid_clear = 1'b0;
    if (br_taken) begin
      // Redirect wins over freeze and works from either state.
      pc_n       = br_target & ~N'(3);
      state_n    = RUN;
      ifid_clear = 1'b1;
    end else if (freeze) begin
      ifid_hold  = 1'b1;
    end else if (state == RUN) begin
      if (in_range) begin
        pc_n = pc_plus4;
      end else begin
        state_n    = FAULT;
        ifid_clear = 1'b1;
      end
    end else begin
      // FAULT: PC parked, keep bubbling until a branch arrives.
      ifid_clear = 1'b1;
    end
  end

  if_id_reg #(.N(N)) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .hold    (ifid_hold),
    .clear   (ifid_clear),
    .pc_d    (pc_plus4),
    .instr_d (instr_in),
    .valid_d (1'b1),
    .pc_q    (if_id_pc),
    .instr_q (if_id_instr),
    .valid_q (if_id_valid)
  );

  assign pc_out      = pc;
  assign fetch_fault = (state == FAULT);

`ifdef IF_PERF_CNT_EN
  logic load_fire;
  assign load_fire = !ifid_clear && !ifid_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (load_fire) fetch_cnt  <= fetch_cnt + 1'b1;
      if (br_taken)  squash_cnt <= squash_cnt + 1'b1;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

  localparam int N = 32;
  localparam int DEPTH = 91;
  localparam logic [31:0] LIMIT = 32'd364;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] pc_out, instr_in, if_id_pc, if_id_instr;
  logic        if_id_valid, fetch_fault;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, squash_cnt;
`endif

  logic [31:0] mem [0:127];
  assign instr_in = mem[pc_out[8:2]];

  if_stage #(.N(N), .RESET_PC(32'd0), .IMEM_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .pc_out      (pc_out),
    .instr_in    (instr_in),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .fetch_fault (fetch_fault)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .squash_cnt  (squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc, m_ipc, m_instr;
  logic        m_valid, m_fault;
  int          m_fetches, m_squashes;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = 0; m_ipc = 0; m_instr = 0; m_valid = 0; m_fault = 0;
      m_fetches = 0; m_squashes = 0;
    end else if (br_taken) begin
      m_pc = {br_target[31:2], 2'b00};
      m_fault = 0; m_ipc = 0; m_instr = 0; m_valid = 0;
      m_squashes++;
    end else if (freeze) begin
      // everything holds
    end else if (m_fault || m_pc >= LIMIT) begin
      m_fault = 1; m_ipc = 0; m_instr = 0; m_valid = 0;
    end else begin
      m_ipc = m_pc + 4;
      m_instr = mem[m_pc[8:2]];
      m_valid = 1;
      m_pc = m_pc + 4;
      m_fetches++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("pc_out", pc_out, m_pc);
      chk("if_id_pc", if_id_pc, m_ipc);
      chk("if_id_instr", if_id_instr, m_instr);
      chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
`ifdef IF_PERF_CNT_EN
      chk("fetch_cnt", fetch_cnt, m_fetches);
      chk("squash_cnt", squash_cnt, m_squashes);
`endif
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc_out, 32'd0);
    chk({tag, "_ifpc"}, if_id_pc, 32'd0);
    chk({tag, "_instr"}, if_id_instr, 32'd0);
    chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'd0);
    chk({tag, "_fault"}, {31'b0, fetch_fault}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 ^ (i * 32'h0001_0101);
    mem[0] = 32'h8020000A;

    #2;
    chk_reset("rst_init");
    #5 rst = 1'b1;            // release between edges
    checking = 1'b1;

    tick(1);                  // first edge after reset
    chk("lit_pc4", pc_out, 32'd4);
    chk("lit_instr0", if_id_instr, 32'h8020000A);
    chk("lit_ifpc4", if_id_pc, 32'd4);
    chk("lit_valid1", {31'b0, if_id_valid}, 32'd1);
    tick(1);
    chk("lit_pc8", pc_out, 32'd8);

    freeze = 1'b1;
    tick(2);
    chk("lit_frz_pc", pc_out, 32'd8);
    chk("lit_frz_ifpc", if_id_pc, 32'd8);
    freeze = 1'b0;
    tick(1);
    chk("lit_rel_pc", pc_out, 32'd12);
    chk("lit_rel_ifpc", if_id_pc, 32'd12);
    tick(2);
    chk("lit_pc20", pc_out, 32'd20);

    br_taken = 1'b1; freeze = 1'b1; br_target = 32'h0000_0107;
    tick(1);
    br_taken = 1'b0; freeze = 1'b0;
    chk("lit_br_pc", pc_out, 32'h0000_0104);
    chk("lit_br_valid", {31'b0, if_id_valid}, 32'd0);
    chk("lit_br_instr", if_id_instr, 32'd0);
    tick(2);

    br_taken = 1'b1; br_target = 32'd356;
    tick(1);
    br_taken = 1'b0;
    tick(1);
    chk("lit_pc360", pc_out, 32'd360);
    chk("lit_ifpc360", if_id_pc, 32'd360);
    tick(1);
    chk("lit_pc364", pc_out, 32'd364);
    tick(1);
    chk("lit_fault", {31'b0, fetch_fault}, 32'd1);
    chk("lit_fault_pc", pc_out, 32'd364);
    chk("lit_fault_valid", {31'b0, if_id_valid}, 32'd0);
    tick(1);
    freeze = 1'b1;
    tick(1);
    freeze = 1'b0;
    chk("lit_fault_hold", {31'b0, fetch_fault}, 32'd1);

    br_taken = 1'b1; br_target = 32'd0;
    tick(1);
    br_taken = 1'b0;
    chk("lit_unfault", {31'b0, fetch_fault}, 32'd0);
    chk("lit_unfault_pc", pc_out, 32'd0);
    tick(3);

    br_taken = 1'b1; br_target = 32'd400;
    tick(1);
    br_taken = 1'b0;
    chk("lit_oor_nofault", {31'b0, fetch_fault}, 32'd0);
    chk("lit_oor_pc", pc_out, 32'd400);
    tick(1);
    chk("lit_oor_fault", {31'b0, fetch_fault}, 32'd1);

    freeze = 1'b1; br_taken = 1'b1; br_target = 32'd8;
    #2 rst = 1'b0;
    #1 chk_reset("rst_mid");
    tick(1);
    chk_reset("rst_held");
    #2 rst = 1'b1;
    freeze = 1'b0; br_taken = 1'b0;
    tick(3);

`ifdef IF_PERF_CNT_EN
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    tick(5);
    freeze = 1'b1;
    tick(1);
    freeze = 1'b0;
    chk("lit_fcnt_frz", fetch_cnt, 32'd5);
    br_taken = 1'b1; br_target = 32'd40;
    tick(1);
    br_taken = 1'b0;
    chk("lit_fcnt", fetch_cnt, 32'd5);
    chk("lit_scnt", squash_cnt, 32'd1);
`endif

    tick(1);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
